// File: rtl/fsm_run_arbiter.sv
// fsm_run_arbiter: round-robin arbiter that sequences one run/done engine among NUM_REQ requesters.
// Optional WAIT timeout is enabled by defining FSM_ARB_TIMEOUT_EN.
module fsm_run_arbiter #(
  parameter int         NUM_REQ     = 4,
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [NUM_REQ-1:0] o_done,
  output logic               o_run,
  input  logic               i_eng_done,
  output logic               o_busy,
  output logic               o_timeout,
  output logic [1:0]         c_state
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, WAIT = 2'b10, DONE = 2'b11} state_t;
  state_t             r_state, w_next;
  logic [NUM_REQ-1:0] r_grant;
  logic [IW-1:0]      r_ptr, r_idx, w_sel;
  logic               w_any, w_to;
  // Scan from ptr+NUM_REQ down to ptr+1 so the nearest set bit after ptr wins last.
  always_comb begin
    w_sel = r_ptr;
    w_any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      automatic int j = (int'(r_ptr) + k) % NUM_REQ;
      if (i_req[j]) begin
        w_sel = IW'(j);
        w_any = 1'b1;
      end
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_any ? RUN : IDLE;
      RUN:     w_next = WAIT;
      WAIT:    w_next = (i_eng_done || w_to) ? DONE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= IW'(NUM_REQ - 1);
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_grant        <= '0;
        r_grant[w_sel] <= 1'b1;
        r_idx          <= w_sel;
      end
      if (r_state == DONE) begin
        r_grant <= '0;
        r_ptr   <= r_idx;
      end
    end
  end
`ifdef FSM_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_to;
  assign w_to = ({1'b0, r_cnt} + 9'd1) == {1'b0, TIMEOUT_CYC};
  // r_to remembers that DONE was reached by the limit rather than by the engine.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else begin
      r_cnt <= (r_state == WAIT) ? r_cnt + 8'd1 : 8'd0;
      r_to  <= (r_state == WAIT) && !i_eng_done && w_to;
    end
  end
  assign o_timeout = (r_state == DONE) && r_to;
`else
  assign w_to      = &{1'b0, TIMEOUT_CYC};
  assign o_timeout = 1'b0;
`endif
  assign o_grant = r_grant;
  assign o_done  = (r_state == DONE) ? r_grant : '0;
  assign o_run   = r_state == RUN;
  assign o_busy  = r_state != IDLE;
  assign c_state = r_state;
endmodule

// File: doc/fsm_run_arbiter.md
# fsm_run_arbiter

- Round-robin arbiter and sequencer sharing one run/done FSM engine (2-bit state, `i_run` start pulse, `o_done` completion pulse) among several requesters.
- Grants one requester at a time and issues a single-cycle run pulse to the engine.
- Waits for the engine's done pulse, then returns a one-cycle done to the granted requester.
- Sits between requester logic and the engine instance, and exposes its own 2-bit state for debug.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, legal 2..8.
- `TIMEOUT_CYC`, default 255: WAIT-state cycle limit, 8-bit; used only with the timeout feature.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `i_req` in NUM_REQ: per-requester level request, held until its `o_done`.
- `o_grant` out NUM_REQ: one-hot grant, held for the whole transaction.
- `o_done` out NUM_REQ: one-cycle completion pulse on the granted bit.
- `o_run` out 1: one-cycle start pulse to engine `i_run`.
- `i_eng_done` in 1: engine `o_done`.
- `o_busy` out 1: high whenever state != IDLE.
- `o_timeout` out 1: one-cycle abort flag, coincident with `o_done`.
- `c_state` out 2: current arbiter state.

## Operation
- **States** (encoding): IDLE=00, RUN=01, WAIT=10, DONE=11.
- **IDLE**
  - If any `i_req` bit is set, select the first set bit searching from `ptr+1` upward, wrapping modulo NUM_REQ.
  - Register the one-hot grant and go to RUN.
  - If no request, stay in IDLE.
- **RUN**
  - `o_run`=1 for exactly this cycle.
  - Unconditional transition to WAIT.
- **WAIT**
  - Stay until `i_eng_done`=1 is sampled, then go to DONE.
- **DONE**
  - `o_done[g]`=1 for this cycle only.
  - Set `ptr`=g, where g is the granted index.
  - Clear `o_grant` at the transition to IDLE.
- **Fairness:** the last-served index has lowest priority next round. `ptr` resets to NUM_REQ-1, so index 0 wins first.
- **Output decoding:** `o_run`, `o_busy` and `o_done` decode from registered state and grant only, with no combinational path from inputs.
- **Boundary conditions:**
  - `i_req` changes after grant are ignored; a dropped request still completes its transaction.
  - `i_eng_done` in IDLE, RUN or DONE is ignored.
  - `i_eng_done` coinciding with the `o_run` cycle is ignored.
  - Several simultaneous requests: exactly one is granted per round-robin order. The others wait and are served in later rounds with no starvation.
  - `reset_n`=0 mid-transaction: next edge forces IDLE, clears grant, clears counter and sets `ptr`=NUM_REQ-1. The engine must share the same `reset_n`.

## Timing
- **Reset values:** `o_grant`=0, `o_done`=0, `o_run`=0, `o_busy`=0, `o_timeout`=0, `c_state`=00.
- **Request to grant:** `i_req` sampled at edge E0 in IDLE gives `o_grant` and `o_run` high in the cycle after E0.
- **Run to WAIT:** `o_busy` high from the cycle after E0; state is WAIT after E1.
- **Done path:** `i_eng_done` sampled at edge Ek gives `o_done` high in cycle Ek+1; IDLE follows at Ek+2.
- **Minimum transaction:** 4 cycles (IDLE, RUN, WAIT, DONE).
- **Back-to-back:** the next grant is issued one cycle after returning to IDLE.

## Configuration
- **`FSM_ARB_TIMEOUT_EN` defined:**
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC without `i_eng_done`, go to DONE and assert `o_done[g]` and `o_timeout` together for one cycle.
  - `i_eng_done` arriving in the same cycle as the limit takes precedence, and `o_timeout` stays 0.
- **Not defined:**
  - WAIT lasts indefinitely.
  - `o_timeout` is tied 0 and no counter is synthesized.

## Test plan
- **Reset:** hold `reset_n`=0 for 10 cycles -> all outputs 0, `c_state`=00.
- **Single requester:** `i_req`=4'b0100, engine done 3 cycles after `o_run` -> `o_grant`=0100, one `o_run` pulse, `o_done`=0100 pulse, `c_state` sequence 00,01,10,...,11,00.
- **Fairness:** `i_req`=4'b1111 held -> grants in order 0001, 0010, 0100, 1000, 0001, each with exactly one `o_done`.
- **Stale inputs:** `i_eng_done` pulsed in IDLE, and requester drops `i_req` during WAIT -> no state change in IDLE; the transaction still completes with `o_done`.
- **Mid-WAIT reset:** `reset_n`=0 for 1 cycle -> IDLE next cycle, grant cleared; next `i_req`=1111 grants 0001.
- **Timeout (macro on):** TIMEOUT_CYC=8, engine never done -> `o_done` and `o_timeout` pulse together after 8 WAIT cycles. With the macro off, the block stays in WAIT for 100 cycles.
